// File: rtl/s27_bist_pkg.sv
// s27_bist_pkg: shared types and constants for the s27 BIST driver.
// FSM state encoding, LFSR/SISR polynomials and the common Galois step.
package s27_bist_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    localparam int          SIG_W    = 16;
    localparam logic [15:0] POLY_PAT = 16'h002D;
    localparam logic [15:0] POLY_SIG = 16'h1021;

    // One Galois shift; sin=0 gives a plain LFSR, sin=data gives a SISR.
    function automatic logic [15:0] galois_step(input logic [15:0] r,
                                                input logic        sin,
                                                input logic [15:0] poly);
        return {r[14:0], 1'b0} ^ (((r[15] ^ sin) == 1'b1) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/s27_bist_driver_if.sv
// s27_bist_driver_if: core-side stimulus/response and test status bundle.
// master = BIST driver, slave = observer/controller side.
// S27_BIST_STEP_EN adds STEP (run gating) and PATNUM (pattern counter).
interface s27_bist_driver_if;
    import s27_bist_pkg::SIG_W;

    logic             START;
    logic             G17;
    logic             G0, G1, G2, G3;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [SIG_W-1:0] SIG;
`ifdef S27_BIST_STEP_EN
    logic             STEP;
    logic [15:0]      PATNUM;

    modport master (input START, G17, STEP,
                    output G0, G1, G2, G3, BUSY, DONE, PASS, SIG, PATNUM);
    modport slave  (output START, G17, STEP,
                    input G0, G1, G2, G3, BUSY, DONE, PASS, SIG, PATNUM);
`else
    modport master (input START, G17,
                    output G0, G1, G2, G3, BUSY, DONE, PASS, SIG);
    modport slave  (output START, G17,
                    input G0, G1, G2, G3, BUSY, DONE, PASS, SIG);
`endif
endinterface

// File: rtl/s27_bist_lfsr16.sv
// s27_bist_lfsr16: 16-bit Galois shift register with synchronous load.
// Used both as pattern generator (sin=0) and as signature register.
module s27_bist_lfsr16
    import s27_bist_pkg::*;
#(
    parameter logic [15:0] POLY = POLY_PAT
) (
    input  logic        CK,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        sin,
    output logic [15:0] q
);

    // Load has priority over stepping so reset/restart always wins.
    always_ff @(posedge CK) begin
        if (load)
            q <= load_val;
        else if (en)
            q <= galois_step(q, sin, POLY);
    end

endmodule

// File: rtl/s27_bist_driver.sv
// s27_bist_driver: BIST driver for the s27 core.
// Flushes the core with a fixed vector, applies PAT_CNT LFSR vectors on
// G0..G3, compacts G17 into a SISR and compares against GOLDEN_SIG.
// Optional macro: S27_BIST_STEP_EN (STEP gates RUN, PATNUM mirrors counter).
module s27_bist_driver
    import s27_bist_pkg::*;
#(
    parameter int unsigned PAT_CNT    = 64,
    parameter int unsigned FLUSH_CYC  = 2,
    parameter logic [3:0]  FLUSH_VEC  = 4'hF,
    parameter logic [15:0] SEED       = 16'h0001,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              CK,
    input  logic              RSTN,
    s27_bist_driver_if.master bus
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [15:0] fcnt;
    logic [15:0] lfsr_q, sig_q;
    logic [15:0] pat_nxt, sig_nxt;
    logic [3:0]  g;
    logic        busy, done, pass;
    logic        init, adv, run_step, flush_last, run_last, ld;
    logic        unused_bits;

`ifdef S27_BIST_STEP_EN
    assign adv        = bus.STEP;
    assign bus.PATNUM = cnt;
`else
    assign adv = 1'b1;
`endif

    assign flush_last = (32'(fcnt) == FLUSH_CYC - 1);
    assign run_last   = (32'(cnt) + 32'd1 == PAT_CNT);
    assign run_step   = (state == RUN) && adv;
    assign ld         = !RSTN || init;

    // Values the registers take on a RUN advance; used for G and the verdict.
    assign pat_nxt     = galois_step(lfsr_q, 1'b0, POLY_PAT);
    assign sig_nxt     = galois_step(sig_q, bus.G17, POLY_SIG);
    assign unused_bits = ^pat_nxt[15:4];

    s27_bist_lfsr16 #(.POLY(POLY_PAT)) u_pat (
        .CK(CK), .load(ld), .load_val(SEED_EFF), .en(run_step),
        .sin(1'b0), .q(lfsr_q)
    );

    s27_bist_lfsr16 #(.POLY(POLY_SIG)) u_sig (
        .CK(CK), .load(ld), .load_val(16'h0000), .en(run_step),
        .sin(bus.G17), .q(sig_q)
    );

    // State register.
    always_ff @(posedge CK) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; START is only honoured when no test is in flight.
    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        case (state)
            IDLE, DONE: if (bus.START) begin
                state_nxt = FLUSH;
                init      = 1'b1;
            end
            FLUSH:   if (flush_last) state_nxt = RUN;
            RUN:     if (adv && run_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters and registered core stimulus / status outputs.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            cnt  <= '0;
            fcnt <= '0;
            g    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else if (init) begin
            cnt  <= '0;
            fcnt <= '0;
            g    <= FLUSH_VEC;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_last) begin
                        fcnt <= '0;
                        g    <= lfsr_q[3:0];
                    end else begin
                        fcnt <= fcnt + 16'd1;
                    end
                end
                RUN: begin
                    if (adv) begin
                        cnt <= cnt + 16'd1;
                        if (run_last) begin
                            g    <= '0;
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (sig_nxt == GOLDEN_SIG);
                        end else begin
                            g <= pat_nxt[3:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.G0   = g[0];
    assign bus.G1   = g[1];
    assign bus.G2   = g[2];
    assign bus.G3   = g[3];
    assign bus.BUSY = busy;
    assign bus.DONE = done;
    assign bus.PASS = pass;
    assign bus.SIG  = sig_q;

endmodule

// File: doc/s27_bist_driver.md
Name: s27_bist_driver

Overview:
- Built-in self-test driver for the s27 benchmark core. It is the driving end of the core's G0..G3 → G17 interface.
- Pseudo-random vectors from a 16-bit LFSR drive G0..G3, and each G17 response is compacted into a 16-bit signature (SISR).
- The block issues a pass/fail verdict against a golden signature.
- It sits beside the s27 instance. It owns the core's inputs and observes its output.

Parameters:
- PAT_CNT, 64: number of RUN vectors applied and captured (1..65535).
- FLUSH_CYC, 2: cycles the flush vector is held before RUN (≥1).
- FLUSH_VEC, 4'hF: flush vector {G3,G2,G1,G0}. With G0=G1=G2=1 the core state is forced to G5=1, G6=0, G7=0 within 1 cycle.
- SEED, 16'h0001: LFSR start value. A value of 0 is replaced by 16'h0001.
- GOLDEN_SIG, 16'h0000: expected final signature.

Ports:
- CK  in  1  clock, rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- START  in  1  pulse to begin a test. Sampled in IDLE and DONE only.
- G17  in  1  core response, combinational from the core.
- G0, G1, G2, G3  out  1 each  registered core stimulus.
- BUSY  out  1  high in FLUSH and RUN.
- DONE  out  1  high in DONE.
- PASS  out  1  valid while DONE=1.
- SIG  out  16  current signature register.

Behaviour:
- Reset (RSTN=0 at an edge; one clock with RSTN low is sufficient, from any state):
  - state=IDLE; G0..G3=0; BUSY, DONE, PASS=0; SIG=0; LFSR=SEED; counter=0.
- LFSR and SISR share one Galois step: r' = (r<<1) ^ ((r[15]^sin) ? POLY : 0).
  - Pattern generator: POLY=16'h002D, sin=0.
  - Signature register: POLY=16'h1021, sin=G17.
- IDLE:
  - START=1 → FLUSH. LFSR reloads SEED, SIG clears, counter clears.
  - BUSY=1 and {G3..G0}=FLUSH_VEC from the next cycle.
- FLUSH:
  - Holds FLUSH_VEC for exactly FLUSH_CYC cycles. SIG does not update.
  - On the last FLUSH edge, {G3..G0} loads LFSR[3:0]; state → RUN.
- RUN, at each edge:
  - SIG captures G17, which is the response to the vector currently driven.
  - LFSR steps; {G3..G0} loads the new LFSR[3:0]; counter increments.
  - At the edge where counter reaches PAT_CNT: state → DONE; G0..G3=0; BUSY=0; DONE=1; PASS=(next SIG==GOLDEN_SIG).
- Total latency: DONE rises FLUSH_CYC+PAT_CNT cycles after BUSY rises.
- DONE:
  - DONE, PASS and SIG hold.
  - START=1 → FLUSH: DONE and PASS clear, full re-init as from IDLE.
- START in FLUSH or RUN is ignored.
- RSTN low mid-FLUSH or mid-RUN aborts to reset values. No partial verdict is produced.
- The counter never wraps; PAT_CNT=65535 is legal.

Optional Feature:
- Macro S27_BIST_STEP_EN.
- When defined:
  - Extra input STEP (1 bit). RUN advances (SIG capture, LFSR step, counter) only on edges where STEP=1; otherwise all RUN state holds.
  - Extra output PATNUM (16 bits) mirrors the counter.
  - FLUSH is unaffected.
- When undefined: no STEP or PATNUM ports; RUN advances every cycle.

Decomposition:
- Package s27_bist_pkg holds:
  - state enum {IDLE, FLUSH, RUN, DONE};
  - POLY_PAT=16'h002D and POLY_SIG=16'h1021;
  - SIG_W=16.
- One sub-module, s27_bist_lfsr16 (parameter POLY; ports CK, load, load_val, en, sin, q[15:0]), instantiated twice: pattern generator and signature register.

Test Plan:
1. Reset: RSTN=0 for 1 cycle → G0..G3=0, BUSY=0, DONE=0, PASS=0, SIG=16'h0000.
2. Default parameters, START pulse → BUSY=1 and {G3..G0}=4'hF for 2 cycles, then RUN vectors 4'h1, 4'h2, 4'h4, 4'h8 on successive cycles.
3. G17 tied 0, GOLDEN_SIG=0 → DONE rises exactly 66 cycles after BUSY, SIG=16'h0000, PASS=1.
4. G17 tied 1, PAT_CNT=1, GOLDEN_SIG=0 → SIG=16'h1021, DONE=1, PASS=0.
5. RSTN low at RUN vector 30 → all outputs return to reset values next cycle; a fresh START gives a signature identical to an uninterrupted run.
6. Core s27 connected, START pulsed during RUN (ignored) → SIG matches the reference-model signature. A START in DONE restarts the test and reproduces the same SIG.
